// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared definitions for the multi-cycle control sequencer.
//  - opcode encodings of the 4-bit-opcode ISA (instr[15:12])
//  - sequencer state encoding
//  - small decode helpers used by the control FSM
package mc_ctrl_pkg;

  localparam logic [3:0] OP_RARITH = 4'b0000;
  localparam logic [3:0] OP_IARITH = 4'b1000;
  localparam logic [3:0] OP_RLOGIC = 4'b0010;
  localparam logic [3:0] OP_ILOGIC = 4'b1010;
  localparam logic [3:0] OP_LOAD   = 4'b1001;
  localparam logic [3:0] OP_STORE  = 4'b0101;
  localparam logic [3:0] OP_BRANCH = 4'b0110;
  localparam logic [3:0] OP_JAL    = 4'b1011;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    ERR    = 3'd6
  } state_t;

  // True for every opcode the sequencer knows how to execute.
  function automatic logic is_legal(input logic [3:0] op);
    case (op)
      OP_RARITH, OP_IARITH, OP_RLOGIC, OP_ILOGIC,
      OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL: is_legal = 1'b1;
      default:                              is_legal = 1'b0;
    endcase
  endfunction

  // True when the ALU second operand comes from the immediate field.
  function automatic logic uses_imm(input logic [3:0] op);
    case (op)
      OP_IARITH, OP_ILOGIC, OP_LOAD, OP_STORE, OP_JAL: uses_imm = 1'b1;
      default:                                         uses_imm = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_mem_wait_timer.sv
// mem_wait_timer: counts un-acknowledged memory request cycles.
//  clk, rst  : clock, synchronous active-high reset
//  clear     : zero the count (asserted in the cycle a request state is entered)
//  count     : this cycle is a request cycle without ack
//  limit     : number of un-acked cycles that constitutes a timeout
//  expired   : this un-acked cycle is the limit-th one
module mem_wait_timer #(
  parameter int TO_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            count,
  input  logic [TO_W-1:0] limit,
  output logic            expired
);

  localparam logic [TO_W-1:0] ONE = TO_W'(1);

  logic [TO_W-1:0] cnt_r;

  // Wait-cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (count) begin
      cnt_r <= cnt_r + ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // cnt_r holds the number of earlier un-acked cycles, so the limit-th one
  // is seen while cnt_r == limit-1; an ack in that cycle suppresses count.
  always_comb begin
    expired = count && (cnt_r == (limit - ONE));
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: FETCH/DECODE/EXEC/MEM/WB sequencer for the 4-bit-opcode
// ISA with a single shared memory port and a req/ack handshake timeout.
// Optional feature macro: MC_ILLEGAL_TRAP_EN (illegal opcode traps to ERR and
// raises the extra 'trap' output; otherwise illegal opcodes execute as NOP).
//  Inputs : clk, rst (sync, active high), run, opcode[3:0], mem_ack
//  Outputs: mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_write_cond,
//           alu_src, mem_to_reg, reg_write, jump, instr_done, busy, bus_err
//           [, trap]
module multicycle_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [3:0] opcode,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       alu_src,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       jump,
  output logic       instr_done,
  output logic       busy,
  output logic       bus_err
`ifdef MC_ILLEGAL_TRAP_EN
  ,
  output logic       trap
`endif
);

  state_t     state_r, state_nxt;
  logic [3:0] opcode_r;
  logic       bus_err_r;
  logic       set_bus_err_s;
  logic       done_s;
  logic       ack_s;
  logic       timer_clear_s;
  logic       timer_count_s;
  logic       expired_s;
`ifdef MC_ILLEGAL_TRAP_EN
  logic       trap_r;
  logic       set_trap_s;
`endif

  // An ack arriving together with reset must not advance anything.
  assign ack_s = mem_ack & ~rst;

  mem_wait_timer #(.TO_W(TO_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear_s),
    .count   (timer_count_s),
    .limit   (TO_W'(MEM_TIMEOUT)),
    .expired (expired_s)
  );

  // State, latched opcode and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      opcode_r  <= 4'b0000;
      bus_err_r <= 1'b0;
`ifdef MC_ILLEGAL_TRAP_EN
      trap_r    <= 1'b0;
`endif
    end else begin
      state_r   <= state_nxt;
      opcode_r  <= (state_r == DECODE) ? opcode : opcode_r;
      bus_err_r <= bus_err_r | set_bus_err_s;
`ifdef MC_ILLEGAL_TRAP_EN
      trap_r    <= trap_r | set_trap_s;
`endif
    end
  end

  // Next-state and datapath-enable decode.
  always_comb begin
    state_nxt     = state_r;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr_sel  = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    alu_src       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    jump          = 1'b0;
    instr_done    = 1'b0;
    done_s        = 1'b0;
    set_bus_err_s = 1'b0;
`ifdef MC_ILLEGAL_TRAP_EN
    set_trap_s    = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (run) state_nxt = FETCH;
        else     state_nxt = IDLE;
      end
      FETCH: begin
        mem_req = 1'b1;
        if (ack_s) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          state_nxt = DECODE;
        end else if (expired_s) begin
          set_bus_err_s = 1'b1;
          state_nxt     = ERR;
        end else begin
          state_nxt = FETCH;
        end
      end
      DECODE: begin
        if (is_legal(opcode)) begin
          state_nxt = EXEC;
        end else begin
`ifdef MC_ILLEGAL_TRAP_EN
          set_trap_s = 1'b1;
          state_nxt  = ERR;
`else
          done_s = 1'b1;
`endif
        end
      end
      EXEC: begin
        alu_src = uses_imm(opcode_r);
        if (opcode_r == OP_BRANCH) begin
          pc_write_cond = 1'b1;
          done_s        = 1'b1;
        end else if ((opcode_r == OP_LOAD) || (opcode_r == OP_STORE)) begin
          state_nxt = MEM;
        end else begin
          state_nxt = WB;
        end
      end
      MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (opcode_r == OP_STORE);
        if (ack_s) begin
          if (opcode_r == OP_STORE) done_s = 1'b1;
          else                      state_nxt = WB;
        end else if (expired_s) begin
          set_bus_err_s = 1'b1;
          state_nxt     = ERR;
        end else begin
          state_nxt = MEM;
        end
      end
      WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (opcode_r == OP_LOAD);
        if (opcode_r == OP_JAL) begin
          jump     = 1'b1;
          pc_write = 1'b1;
        end else begin
          jump     = 1'b0;
        end
        done_s = 1'b1;
      end
      ERR: begin
        state_nxt = ERR;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Instruction boundary: run decides whether to keep issuing.
    if (done_s) begin
      instr_done = 1'b1;
      state_nxt  = run ? FETCH : IDLE;
    end else begin
      instr_done = 1'b0;
    end
  end

  // Timer bookkeeping: zero on entry to a request state, count un-acked cycles.
  always_comb begin
    timer_clear_s = ((state_nxt == FETCH) || (state_nxt == MEM)) && (state_nxt != state_r);
    timer_count_s = ((state_r == FETCH) || (state_r == MEM)) && !ack_s;
  end

  assign busy    = (state_r != IDLE);
  assign bus_err = bus_err_r;
`ifdef MC_ILLEGAL_TRAP_EN
  assign trap    = trap_r;
`endif

endmodule
